bubble_sort_top: RTL and testbench

- Fully pipelined odd-even transposition ("brick") sorting network.
- Sorts 2**LOG_INPUT_NUM words of DATA_WIDTH bits, accepting one new vector per clock.
- Built from N = 2**LOG_INPUT_NUM register-separated compare-and-exchange stages, with a parallel valid pipeline.
- Used as a standalone hardware sorting accelerator fed by a flat packed vector bus.

---
 rtl/bubble_sort_top.sv | 101 ++++++++++
 tb/tb_bubble_sort_top.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bubble_sort_top.sv
// Fully pipelined odd-even transposition sorting network: N register-separated
// compare-and-exchange stages with a parallel valid pipeline, one vector per clock.
module bubble_sort_top #(
  parameter int unsigned LOG_INPUT_NUM = 4,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          SIGNED        = 1'b0,
  parameter bit          ASCENDING     = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      x_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  x,
  output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  y,
  output logic                                      y_valid
);

  localparam int N = 2 ** LOG_INPUT_NUM;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t      x_words  [N];
  word_t      stage_in [N][N];
  word_t      data_d   [N][N];
  word_t      data_q   [N][N];
  logic [N-1:0] valid_q;

  // True when the pair (lo, hi) must be exchanged; equal values never swap.
  function automatic logic out_of_order(word_t lo, word_t hi);
    logic lo_gt_hi;
    logic hi_gt_lo;
    if (SIGNED) begin
      lo_gt_hi = $signed(lo) > $signed(hi);
      hi_gt_lo = $signed(hi) > $signed(lo);
    end else begin
      lo_gt_hi = lo > hi;
      hi_gt_lo = hi > lo;
    end
    return ASCENDING ? lo_gt_hi : hi_gt_lo;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      x_words[i] = x[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    word_t a;
    word_t b;
    a = '0;
    b = '0;
    for (int i = 0; i < N; i++) begin
      stage_in[0][i] = x_words[i];
    end
    for (int s = 1; s < N; s++) begin
      for (int i = 0; i < N; i++) begin
        stage_in[s][i] = data_q[s-1][i];
      end
    end
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < N; i++) begin
        data_d[s][i] = stage_in[s][i];
      end
      // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)... and pass the ends.
      for (int lo = s % 2; lo + 1 < N; lo += 2) begin
        a = stage_in[s][lo];
        b = stage_in[s][lo+1];
        if (out_of_order(a, b)) begin
          data_d[s][lo]   = b;
          data_d[s][lo+1] = a;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N; s++) begin
        for (int i = 0; i < N; i++) begin
          data_q[s][i] <= '0;
        end
      end
      valid_q <= '0;
    end else begin
      data_q     <= data_d;
      valid_q[0] <= x_valid;
      for (int s = 1; s < N; s++) begin
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      y[i*DATA_WIDTH +: DATA_WIDTH] = data_q[N-1][i];
    end
    y_valid = valid_q[N-1];
  end

endmodule

// File: tb/tb_bubble_sort_top.sv
// Directed bench for bubble_sort_top: unsigned-ascending, signed-ascending and
// unsigned-descending instances share one stimulus stream.
module tb_bubble_sort_top;

  localparam int N = 16;
  localparam int W = 32;
  localparam int K = 7;

  typedef logic [W-1:0]   word_t;
  typedef word_t          vec_t [N];
  typedef logic [N*W-1:0] bus_t;

  logic clk;
  logic rst;
  logic x_valid;
  bus_t x;
  bus_t y_u, y_s, y_d;
  logic y_valid_u, y_valid_s, y_valid_d;

  int checks = 0;
  int errors = 0;

  vec_t vin [K];
  vec_t eu  [K];
  vec_t es  [K];
  vec_t ed  [K];
  bit   vv  [K];

  bubble_sort_top #(
    .LOG_INPUT_NUM(4), .DATA_WIDTH(W), .SIGNED(1'b0), .ASCENDING(1'b1)
  ) u_dut_u (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .y(y_u), .y_valid(y_valid_u)
  );

  bubble_sort_top #(
    .LOG_INPUT_NUM(4), .DATA_WIDTH(W), .SIGNED(1'b1), .ASCENDING(1'b1)
  ) u_dut_s (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .y(y_s), .y_valid(y_valid_s)
  );

  bubble_sort_top #(
    .LOG_INPUT_NUM(4), .DATA_WIDTH(W), .SIGNED(1'b0), .ASCENDING(1'b0)
  ) u_dut_d (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .y(y_d), .y_valid(y_valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input bus_t got, input bus_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bus_t pack(input vec_t v);
    bus_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = v[i];
    return r;
  endfunction

  function automatic vec_t rev(input vec_t v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    int j;

    vin[0] = '{32'h0F, 32'h0E, 32'h0D, 32'h0C, 32'h0B, 32'h0A, 32'h09, 32'h08,
               32'h07, 32'h06, 32'h05, 32'h04, 32'h03, 32'h02, 32'h01, 32'h00};
    eu[0]  = '{32'h00, 32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06, 32'h07,
               32'h08, 32'h09, 32'h0A, 32'h0B, 32'h0C, 32'h0D, 32'h0E, 32'h0F};
    es[0]  = eu[0];
    ed[0]  = vin[0];
    vv[0]  = 1'b1;

    vin[1] = eu[0];
    eu[1]  = eu[0];
    es[1]  = eu[0];
    ed[1]  = vin[0];
    vv[1]  = 1'b1;

    for (int i = 0; i < N; i++) vin[2][i] = 32'hDEADBEEF;
    eu[2] = vin[2];
    es[2] = vin[2];
    ed[2] = vin[2];
    vv[2] = 1'b1;

    vin[3] = '{32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h5, 32'h3, 32'hFFFFFFFE,
               32'h1, 32'h10, 32'h2, 32'h80000001, 32'h7, 32'h100, 32'h4, 32'h6, 32'h8};
    eu[3]  = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h10,
               32'h100, 32'h7FFFFFFF, 32'h80000000, 32'h80000001, 32'hFFFFFFFE, 32'hFFFFFFFF};
    es[3]  = '{32'h80000000, 32'h80000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h2,
               32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h10, 32'h100, 32'h7FFFFFFF};
    ed[3]  = rev(eu[3]);
    vv[3]  = 1'b1;

    vin[4] = '{32'h9000, 32'h2000, 32'hF000, 32'h0000, 32'h7000, 32'h4000, 32'hB000,
               32'h1000, 32'hE000, 32'h5000, 32'h3000, 32'hC000, 32'h8000, 32'hA000,
               32'h6000, 32'hD000};
    eu[4]  = '{32'h0000, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000, 32'h6000,
               32'h7000, 32'h8000, 32'h9000, 32'hA000, 32'hB000, 32'hC000, 32'hD000,
               32'hE000, 32'hF000};
    es[4]  = eu[4];
    ed[4]  = rev(eu[4]);
    vv[4]  = 1'b1;

    vin[5] = '{32'h5, 32'h5, 32'h1, 32'h1, 32'h9, 32'h9, 32'h3, 32'h3,
               32'h0, 32'h0, 32'h7, 32'h7, 32'h2, 32'h2, 32'h8, 32'h8};
    eu[5]  = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h2, 32'h2, 32'h3, 32'h3,
               32'h5, 32'h5, 32'h7, 32'h7, 32'h8, 32'h8, 32'h9, 32'h9};
    es[5]  = eu[5];
    ed[5]  = rev(eu[5]);
    vv[5]  = 1'b1;

    vin[6] = vin[4];
    eu[6]  = eu[4];
    es[6]  = es[4];
    ed[6]  = ed[4];
    vv[6]  = 1'b0;

    rst = 1'b1;
    x_valid = 1'b0;
    x = '0;
    step();
    check("rst_y_u", y_u, '0);
    check("rst_y_s", y_s, '0);
    check("rst_y_d", y_d, '0);
    check("rst_vld", bus_t'({y_valid_u, y_valid_s, y_valid_d}), '0);
    rst = 1'b0;

    // Stream all vectors back-to-back; vector c emerges after edge c+N-1.
    for (int c = 0; c < K + N; c++) begin
      if (c < K) begin
        x = pack(vin[c]);
        x_valid = vv[c];
      end else begin
        x = '0;
        x_valid = 1'b0;
      end
      step();
      if (c == N - 2) check("early_vld", bus_t'({y_valid_u, y_valid_s, y_valid_d}), '0);
      j = c - (N - 1);
      if (j >= 0 && j < K) begin
        check($sformatf("vld_u%0d", j), bus_t'(y_valid_u), bus_t'(vv[j]));
        check($sformatf("vld_s%0d", j), bus_t'(y_valid_s), bus_t'(vv[j]));
        check($sformatf("vld_d%0d", j), bus_t'(y_valid_d), bus_t'(vv[j]));
        if (vv[j]) begin
          check($sformatf("y_u%0d", j), y_u, pack(eu[j]));
          check($sformatf("y_s%0d", j), y_s, pack(es[j]));
          check($sformatf("y_d%0d", j), y_d, pack(ed[j]));
        end
      end
    end

    // Reset with vectors in flight.
    for (int c = 0; c < 6; c++) begin
      x = pack(vin[c % 3]);
      x_valid = (c < 3);
      step();
    end
    rst = 1'b1;
    x = pack(vin[4]);
    x_valid = 1'b1;
    step();
    check("mid_rst_y_u", y_u, '0);
    check("mid_rst_y_d", y_d, '0);
    check("mid_rst_vld", bus_t'({y_valid_u, y_valid_s, y_valid_d}), '0);
    rst = 1'b0;
    x_valid = 1'b0;
    x = '0;
    seen = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      step();
      if (y_valid_u || y_valid_s || y_valid_d) seen = 1'b1;
    end
    check("stale_vld", bus_t'(seen), '0);

    // Constant valid input: y_valid rises after N edges and holds with constant y.
    x = pack(vin[4]);
    x_valid = 1'b1;
    for (int c = 0; c < N + 3; c++) begin
      step();
      if (c == N - 2) check("hold_early", bus_t'(y_valid_u), '0);
      if (c >= N - 1) begin
        check($sformatf("hold_vld%0d", c), bus_t'(y_valid_u), bus_t'(1'b1));
        check($sformatf("hold_y%0d", c), y_u, pack(eu[4]));
      end
    end
    x_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
